// File: rtl/ccss_reg_pkg.sv
// Shared register-map definitions for the register read/write decoders.
// Holds the register select codes, register count and read-port FSM encodings.
package ccss_reg_pkg;

   localparam int NUM_REGS   = 14;
   localparam int REG_DATA_W = 16;

   // Register select codes (code 0 and 15..31 are unmapped)
   localparam logic [4:0] REG_N    = 5'd1;
   localparam logic [4:0] REG_M    = 5'd2;
   localparam logic [4:0] REG_P    = 5'd3;
   localparam logic [4:0] REG_ROW  = 5'd4;
   localparam logic [4:0] REG_COL  = 5'd5;
   localparam logic [4:0] REG_CURR = 5'd6;
   localparam logic [4:0] REG_SUM  = 5'd7;
   localparam logic [4:0] REG_AVAL = 5'd8;
   localparam logic [4:0] REG_STA  = 5'd9;
   localparam logic [4:0] REG_STB  = 5'd10;
   localparam logic [4:0] REG_STC  = 5'd11;
   localparam logic [4:0] REG_A    = 5'd12;
   localparam logic [4:0] REG_B    = 5'd13;
   localparam logic [4:0] REG_AC   = 5'd14;

   // Read-port FSM encodings
   localparam logic [0:0] RFR_IDLE  = 1'b0;
   localparam logic [0:0] RFR_DRIVE = 1'b1;

   // True when the code selects a mapped register
   function automatic logic reg_code_valid(input logic [4:0] code);
      return (code >= REG_N) && (code <= REG_AC);
   endfunction

endpackage

// File: rtl/rfr_sel_mux.sv
// Combinational register select for the read port: picks one DATA_W slice
// of the flattened register bank, flags whether the code is mapped, and
// produces the one-hot of the selected register. Unmapped codes give zero data.
import ccss_reg_pkg::*;

module rfr_sel_mux #(
   parameter int DATA_W = 16
) (
   input  logic [4:0]                 sel,
   input  logic [NUM_REGS*DATA_W-1:0] regs_flat,
   output logic [DATA_W-1:0]          data,
   output logic                       code_ok,
   output logic [NUM_REGS-1:0]        onehot
);

   // Decode the select code into data, valid flag and one-hot
   always_comb begin
      data    = '0;
      onehot  = '0;
      code_ok = reg_code_valid(sel);
      for (int k = 0; k < NUM_REGS; k++) begin
         if (sel == 5'(k + 1)) begin
            data      = regs_flat[k*DATA_W +: DATA_W];
            onehot[k] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rfr_read_port.sv
// Register read port: snapshots the selected register onto the shared read
// bus and holds it under a valid/ack handshake.
//
// Handshake: a request is taken on a rising edge where rd_req & rd_ready.
// The captured word appears on bus_data with bus_valid=1 one cycle later and
// is held stable until a rising edge where bus_ack=1; that same edge may take
// the next request so a consumer acking every cycle sees one word per cycle.
// bus_ack while bus_valid=0 has no effect.
//
// Optional feature: define RFR_PARITY_EN to register even parity of the bus
// word on bus_par; otherwise bus_par is tied low.
import ccss_reg_pkg::*;

module rfr_read_port #(
   parameter int DATA_W   = 16,
   parameter int NUM_REGS = 14   // fixed by the register map
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       rd_req,
   input  logic [4:0]                 rd_sel,
   output logic                       rd_ready,
   input  logic [NUM_REGS*DATA_W-1:0] regs_flat,
   output logic [DATA_W-1:0]          bus_data,
   output logic                       bus_valid,
   input  logic                       bus_ack,
   output logic                       rd_err,
   output logic [NUM_REGS-1:0]        rd_onehot,
   output logic                       bus_par,
   output logic                       state_dbg
);

   logic [0:0]          state;
   logic [DATA_W-1:0]   mux_data;
   logic                mux_ok;
   logic [NUM_REGS-1:0] mux_onehot;
   logic                accept;
   logic                release_bus;

   rfr_sel_mux #(
      .DATA_W (DATA_W)
   ) u_sel_mux (
      .sel       (rd_sel),
      .regs_flat (regs_flat),
      .data      (mux_data),
      .code_ok   (mux_ok),
      .onehot    (mux_onehot)
   );

   assign rd_ready    = (state == RFR_IDLE) | ((state == RFR_DRIVE) & bus_ack);
   assign accept      = rd_req & rd_ready;
   assign release_bus = (state == RFR_DRIVE) & bus_ack & ~rd_req;
   assign bus_valid   = (state == RFR_DRIVE);
   assign state_dbg   = state;

   // FSM and capture registers: load on accept, clear when the bus drains
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= RFR_IDLE;
         bus_data  <= '0;
         rd_err    <= 1'b0;
         rd_onehot <= '0;
      end else if (accept) begin
         state     <= RFR_DRIVE;
         bus_data  <= mux_data;
         rd_err    <= ~mux_ok;
         rd_onehot <= mux_onehot;
      end else if (release_bus) begin
         state     <= RFR_IDLE;
         bus_data  <= '0;
         rd_err    <= 1'b0;
         rd_onehot <= '0;
      end
   end

`ifdef RFR_PARITY_EN
   // Parity tracks the captured word; unmapped codes carry zero data, so parity 0
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bus_par <= 1'b0;
      end else if (accept) begin
         bus_par <= ^mux_data;
      end else if (release_bus) begin
         bus_par <= 1'b0;
      end
   end
`else
   assign bus_par = 1'b0;
`endif

endmodule

// File: tb/tb_rfr_read_port.sv
// Self-checking bench for rfr_read_port: directed cases plus a random phase,
// with delivered bus words checked against a queue of expected words.
import ccss_reg_pkg::*;

module tb_rfr_read_port;

   localparam int W  = 16;
   localparam int NR = 14;
   localparam int EW = 32;   // {par, err, onehot[13:0], data[15:0]}

`ifdef RFR_PARITY_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic              rd_req = 1'b0;
   logic [4:0]        rd_sel = '0;
   logic              rd_ready;
   logic [NR*W-1:0]   regs_flat;
   logic [W-1:0]      bus_data;
   logic              bus_valid;
   logic              bus_ack = 1'b0;
   logic              rd_err;
   logic [NR-1:0]     rd_onehot;
   logic              bus_par;
   logic              state_dbg;

   logic [W-1:0] regs [NR];

   always_comb begin
      regs_flat = '0;
      for (int k = 0; k < NR; k++) regs_flat[k*W +: W] = regs[k];
   end

   rfr_read_port dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rd_req    (rd_req),
      .rd_sel    (rd_sel),
      .rd_ready  (rd_ready),
      .regs_flat (regs_flat),
      .bus_data  (bus_data),
      .bus_valid (bus_valid),
      .bus_ack   (bus_ack),
      .rd_err    (rd_err),
      .rd_onehot (rd_onehot),
      .bus_par   (bus_par),
      .state_dbg (state_dbg)
   );

   // ---------------- checking ----------------
   int checks   = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [EW-1:0] got, input logic [EW-1:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=%h expected=%h @%0t", tag, got, exp, $time);
      end
   endtask

   // Reference model of one bus word for a select code, from the bench's register copy
   function automatic logic [EW-1:0] model(input logic [4:0] sel);
      logic [W-1:0]  d;
      logic [NR-1:0] oh;
      logic          e;
      logic          p;
      d  = '0;
      oh = '0;
      e  = 1'b1;
      if (sel >= 5'd1 && sel <= 5'd14) begin
         d  = regs[int'(sel) - 1];
         oh = NR'(1) << (int'(sel) - 1);
         e  = 1'b0;
      end
      p = PAR_EN ? ^d : 1'b0;
      return {p, e, oh, d};
   endfunction

   function automatic logic [EW-1:0] cur_word();
      return {bus_par, rd_err, rd_onehot, bus_data};
   endfunction

   // ---------------- scoreboard ----------------
   logic [EW-1:0] exp_q[$];
   logic          hold_pending = 1'b0;
   logic [EW-1:0] hold_word    = '0;

   // Sampled on the falling edge: pop delivered words, push accepted requests
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         hold_pending = 1'b0;
      end else begin
         if (hold_pending) chk("hold_stable", cur_word(), hold_word);
         if (bus_valid && bus_ack) begin
            if (exp_q.size() == 0) chk("sb_underflow", 32'(exp_q.size()), 32'd1);
            else chk("sb_word", cur_word(), exp_q.pop_front());
         end
         hold_pending = bus_valid && !bus_ack;
         hold_word    = cur_word();
         if (rd_req && rd_ready) exp_q.push_back(model(rd_sel));
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic request(input logic [4:0] sel);
      rd_req = 1'b1;
      rd_sel = sel;
      tick();
      rd_req = 1'b0;
   endtask

   task automatic ack_once();
      bus_ack = 1'b1;
      tick();
      bus_ack = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      for (int k = 0; k < NR; k++) regs[k] = 16'(k * 16'h0111 + 16'h0100);

      // 1: reset held with a pending request
      rst_n  = 1'b0;
      rd_req = 1'b1;
      rd_sel = REG_SUM;
      tick();
      tick();
      chk("rst_valid",  32'(bus_valid), 32'd0);
      chk("rst_data",   32'(bus_data),  32'd0);
      chk("rst_err",    32'(rd_err),    32'd0);
      chk("rst_onehot", 32'(rd_onehot), 32'd0);
      chk("rst_par",    32'(bus_par),   32'd0);
      chk("rst_state",  32'(state_dbg), 32'(RFR_IDLE));
      rd_req = 1'b0;
      rst_n  = 1'b1;
      tick();
      chk("rst_ready", 32'(rd_ready), 32'd1);

      // 2: single read of SUM, acked on the third cycle
      regs[6] = 16'h1234;
      request(REG_SUM);
      for (int c = 0; c < 3; c++) begin
         chk("single_valid",  32'(bus_valid), 32'd1);
         chk("single_data",   32'(bus_data),  32'h1234);
         chk("single_onehot", 32'(rd_onehot), 32'h0040);
         if (c < 2) tick();
      end
      ack_once();
      chk("single_done_valid", 32'(bus_valid), 32'd0);
      chk("single_done_data",  32'(bus_data),  32'd0);

      // 3: back-to-back N then AC with ack every cycle
      regs[0]  = 16'h0005;
      regs[13] = 16'hBEEF;
      bus_ack  = 1'b1;
      rd_req   = 1'b1;
      rd_sel   = REG_N;
      tick();
      chk("b2b_ready",   32'(rd_ready),  32'd1);
      chk("b2b_data0",   32'(bus_data),  32'h0005);
      chk("b2b_onehot0", 32'(rd_onehot), 32'h0001);
      rd_sel = REG_AC;
      tick();
      rd_req = 1'b0;
      chk("b2b_valid1",  32'(bus_valid), 32'd1);
      chk("b2b_data1",   32'(bus_data),  32'hBEEF);
      chk("b2b_onehot1", 32'(rd_onehot), 32'h2000);
      tick();
      bus_ack = 1'b0;
      chk("b2b_done", 32'(bus_valid), 32'd0);

      // 4: snapshot holds while the source register changes; stalled request ignored
      regs[11] = 16'h00AA;
      request(REG_A);
      regs[11] = 16'h0055;
      tick();
      chk("snap_data", 32'(bus_data), 32'h00AA);
      rd_req = 1'b1;
      rd_sel = REG_P;
      chk("stall_ready", 32'(rd_ready), 32'd0);
      tick();
      rd_req = 1'b0;
      chk("snap_data2",  32'(bus_data),  32'h00AA);
      chk("snap_onehot", 32'(rd_onehot), 32'h0800);
      ack_once();
      chk("snap_done", 32'(bus_valid), 32'd0);

      // 5: unmapped codes still complete the handshake
      request(5'd0);
      chk("inv0_valid",  32'(bus_valid), 32'd1);
      chk("inv0_data",   32'(bus_data),  32'd0);
      chk("inv0_err",    32'(rd_err),    32'd1);
      chk("inv0_onehot", 32'(rd_onehot), 32'd0);
      ack_once();
      chk("inv0_clear_err", 32'(rd_err), 32'd0);
      request(5'd20);
      chk("inv20_err",   32'(rd_err),    32'd1);
      chk("inv20_data",  32'(bus_data),  32'd0);
      ack_once();
      chk("inv20_done",  32'(bus_valid), 32'd0);
      ack_once();
      chk("idle_ack_ignored", 32'(bus_valid), 32'd0);

      // 6: parity words, then reset while a word is unacked
      regs[1] = 16'h0007;
      regs[2] = 16'h0003;
      request(REG_M);
      chk("par7", 32'(bus_par), 32'(PAR_EN));
      ack_once();
      request(REG_P);
      chk("par3", 32'(bus_par), 32'd0);
      ack_once();
      request(REG_SUM);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("midrst_valid", 32'(bus_valid), 32'd0);
      chk("midrst_state", 32'(state_dbg), 32'(RFR_IDLE));
      chk("midrst_data",  32'(bus_data),  32'd0);
      tick();

      // random phase
      for (int i = 0; i < 300; i++) begin
         rd_req  = 1'($urandom_range(0, 1));
         rd_sel  = 5'($urandom_range(0, 31));
         bus_ack = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 3) == 0) regs[$urandom_range(0, NR - 1)] = 16'($urandom);
         tick();
      end

      // drain, bounded
      rd_req  = 1'b0;
      bus_ack = 1'b1;
      for (int i = 0; i < 20 && (bus_valid || exp_q.size() != 0); i++) tick();
      bus_ack = 1'b0;
      tick();
      chk("sb_drained", 32'(exp_q.size()), 32'd0);
      chk("end_idle",   32'(bus_valid),    32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
